// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction/handshake inputs and decoded control outputs of the sequencer
interface control_sequencer_if #(parameter int IW = 8);
    logic [IW-1:0] instr;
    logic          mem_ready;
    logic          zero;
    logic          li, lw, sw, addi, beq, slti, add, jump;
    logic          lireg;
    logic          ir_write;
    logic          pc_write;
    logic [1:0]    pc_src;
    logic          mem_read;
    logic          mem_write;
    logic          reg_write;
    logic [2:0]    state;

    // Sequencer side: consumes instruction and handshakes, drives control
    modport master (
        input  instr, mem_ready, zero,
        output li, lw, sw, addi, beq, slti, add, jump, lireg,
        output ir_write, pc_write, pc_src, mem_read, mem_write, reg_write, state
    );

    // Datapath side: supplies instruction and handshakes, consumes control
    modport slave (
        output instr, mem_ready, zero,
        input  li, lw, sw, addi, beq, slti, add, jump, lireg,
        input  ir_write, pc_write, pc_src, mem_read, mem_write, reg_write, state
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with one-hot op decode
module control_sequencer #(parameter int IW = 8) (
    input  logic                clk,
    input  logic                rst_n,
    control_sequencer_if.master bus
);
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;

    // Flag bit positions; opcode n maps to bit 7-n
    localparam int LI = 7, LW = 6, SW = 5, ADDI = 4, BEQ = 3, SLTI = 2, ADD = 1, JUMP = 0;

    state_t     state_q, state_d;
    logic [7:0] op_q, op_d;
    logic       lireg_q, lireg_d;
    logic [2:0] opcode;

    assign opcode = bus.instr[IW-1 -: 3];

    // State register, forced to FETCH asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Op flag and lireg registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            lireg_q <= 1'b0;
        end else begin
            op_q    <= op_d;
            lireg_q <= lireg_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE:  state_d = EXEC;
            EXEC:    state_d = (op_q[LW] || op_q[SW]) ? MEM : (op_q[BEQ] || op_q[JUMP]) ? FETCH : WB;
            MEM:     state_d = !bus.mem_ready ? MEM : op_q[LW] ? WB : FETCH;
            WB:      state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Flags load from instr at DECODE->EXEC and clear on every entry to FETCH
    always_comb begin
        op_d    = op_q;
        lireg_d = lireg_q;
        if (state_q == DECODE) begin
            op_d    = 8'h80 >> opcode;
            lireg_d = (opcode == 3'b000) && bus.instr[IW-4];
        end else if (state_d == FETCH) begin
            op_d    = '0;
            lireg_d = 1'b0;
        end
    end

    // Strobes from state, flags and inputs; gated by rst_n so reset silences them at once
    always_comb begin
        bus.ir_write  = 1'b0;
        bus.pc_write  = 1'b0;
        bus.pc_src    = 2'b00;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.reg_write = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    bus.mem_read = 1'b1;
                    bus.ir_write = bus.mem_ready;
                    bus.pc_write = bus.mem_ready;
                end
                EXEC: begin
                    bus.pc_write = (op_q[BEQ] && bus.zero) || op_q[JUMP];
                    bus.pc_src   = op_q[JUMP] ? 2'b10 : (op_q[BEQ] && bus.zero) ? 2'b01 : 2'b00;
                end
                MEM: begin
                    bus.mem_read  = op_q[LW];
                    bus.mem_write = op_q[SW];
                end
                WB:      bus.reg_write = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.li    = op_q[LI];
    assign bus.lw    = op_q[LW];
    assign bus.sw    = op_q[SW];
    assign bus.addi  = op_q[ADDI];
    assign bus.beq   = op_q[BEQ];
    assign bus.slti  = op_q[SLTI];
    assign bus.add   = op_q[ADD];
    assign bus.jump  = op_q[JUMP];
    assign bus.lireg = lireg_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: table-driven per-cycle checks of the control sequencer
module tb_control_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    control_sequencer_if #(.IW(8)) bus();

    control_sequencer #(.IW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] instr;
        logic       mr;
        logic       z;
        logic [7:0] flags;
        logic       lireg;
        logic [6:0] strb;
        logic [2:0] st;
    } vec_t;

    vec_t vecs[$];

    // strobe packing: {ir_write, pc_write, pc_src[1:0], mem_read, mem_write, reg_write}
    localparam logic [6:0] NO = 7'b0000000;
    localparam logic [6:0] FS = 7'b1100100;
    localparam logic [6:0] FW = 7'b0000100;
    localparam logic [6:0] RW = 7'b0000001;
    localparam logic [6:0] MR = 7'b0000100;
    localparam logic [6:0] MW = 7'b0000010;
    localparam logic [6:0] BR = 7'b0101000;
    localparam logic [6:0] JP = 7'b0110000;

    function automatic logic [18:0] act();
        return {bus.li, bus.lw, bus.sw, bus.addi, bus.beq, bus.slti, bus.add, bus.jump,
                bus.lireg, bus.ir_write, bus.pc_write, bus.pc_src, bus.mem_read,
                bus.mem_write, bus.reg_write, bus.state};
    endfunction

    task automatic chk(input string name, input logic [18:0] a, input logic [18:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%05h want=%05h", name, a, e);
        end
    endtask

    task automatic addv(input logic [7:0] i, input logic m, input logic z, input logic [7:0] f,
                        input logic l, input logic [6:0] s, input logic [2:0] st);
        vec_t v;
        v.instr = i; v.mr = m; v.z = z; v.flags = f; v.lireg = l; v.strb = s; v.st = st;
        vecs.push_back(v);
    endtask

    initial begin
        // add
        addv(8'hC0, 1, 0, 8'h00, 0, FS, 0);
        addv(8'hC0, 1, 0, 8'h00, 0, NO, 1);
        addv(8'hC0, 1, 0, 8'h02, 0, NO, 2);
        addv(8'hC0, 1, 0, 8'h02, 0, RW, 4);
        // lw with two wait cycles in MEM
        addv(8'h20, 1, 0, 8'h00, 0, FS, 0);
        addv(8'h20, 1, 0, 8'h00, 0, NO, 1);
        addv(8'h20, 0, 0, 8'h40, 0, NO, 2);
        addv(8'h20, 0, 0, 8'h40, 0, MR, 3);
        addv(8'h20, 0, 0, 8'h40, 0, MR, 3);
        addv(8'h20, 1, 0, 8'h40, 0, MR, 3);
        addv(8'h20, 0, 0, 8'h40, 0, RW, 4);
        // beq taken
        addv(8'h80, 1, 1, 8'h00, 0, FS, 0);
        addv(8'h80, 0, 1, 8'h00, 0, NO, 1);
        addv(8'h80, 0, 1, 8'h08, 0, BR, 2);
        // beq not taken
        addv(8'h9F, 1, 0, 8'h00, 0, FS, 0);
        addv(8'h9F, 1, 1, 8'h00, 0, NO, 1);
        addv(8'h9F, 1, 0, 8'h08, 0, NO, 2);
        // jump
        addv(8'hE0, 1, 0, 8'h00, 0, FS, 0);
        addv(8'hE0, 1, 0, 8'h00, 0, NO, 1);
        addv(8'hE0, 1, 0, 8'h01, 0, JP, 2);
        // sw
        addv(8'h40, 1, 0, 8'h00, 0, FS, 0);
        addv(8'h40, 1, 0, 8'h00, 0, NO, 1);
        addv(8'h40, 1, 0, 8'h20, 0, NO, 2);
        addv(8'h40, 1, 0, 8'h20, 0, MW, 3);
        // li with lireg=1, instr[4] dropped after DECODE
        addv(8'h10, 1, 0, 8'h00, 0, FS, 0);
        addv(8'h10, 1, 0, 8'h00, 0, NO, 1);
        addv(8'h00, 1, 0, 8'h80, 1, NO, 2);
        addv(8'h00, 1, 0, 8'h80, 1, RW, 4);
        // fetch stall, instr changing in FETCH, li with lireg=0
        addv(8'hE0, 0, 0, 8'h00, 0, FW, 0);
        addv(8'hE0, 1, 0, 8'h00, 0, FS, 0);
        addv(8'h00, 1, 0, 8'h00, 0, NO, 1);
        addv(8'h10, 1, 0, 8'h80, 0, NO, 2);
        addv(8'h10, 1, 0, 8'h80, 0, RW, 4);
        addv(8'h10, 0, 0, 8'h00, 0, FW, 0);

        // reset held while inputs toggle
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.instr = 8'(i * 8'h47);
            bus.mem_ready = i[0];
            bus.zero = ~i[0];
            @(negedge clk);
            chk("reset_hold", act(), 19'h0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.instr = vecs[i].instr;
            bus.mem_ready = vecs[i].mr;
            bus.zero = vecs[i].z;
            #2;
            chk($sformatf("vec%0d", i),
                act(), {vecs[i].flags, vecs[i].lireg, vecs[i].strb, vecs[i].st});
            @(posedge clk);
            #1;
        end

        // async reset in the middle of WB of an add
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.instr = 8'hC0;
        bus.mem_ready = 1'b1;
        bus.zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("add_wb", act(), {8'h02, 1'b0, RW, 3'd4});
        rst_n = 1'b0;
        #1;
        chk("reset_mid_wb", act(), 19'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("after_reset", act(), {8'h00, 1'b0, FS, 3'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
